// File: rtl/sram_ctrl_pkg.sv
// Shared types and default geometry for the port-0 request controller of the
// 32x1024 single-port SRAM macro.
package sram_ctrl_pkg;

   localparam int SRAM_DATA_WIDTH = 32;
   localparam int SRAM_ADDR_WIDTH = 10;
   localparam int SRAM_NUM_WMASKS = 4;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Small synchronous show-ahead FIFO holding captured read data until the
// consumer takes it. The caller guarantees no push when full and no pop when
// empty (the request credit logic enforces this).
module sram_rsp_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk0,
   input  logic             rst0,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] pop_data_o,
   output logic [CNT_W-1:0] count_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] cnt_q;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   // Storage array: written on push, no reset needed since count gates validity.
   always_ff @(posedge clk0) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count unchanged.
   always_ff @(posedge clk0) begin
      if (rst0) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_i) begin
            wr_ptr_q <= ptr_inc(wr_ptr_q);
         end
         if (pop_i) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         case ({push_i, pop_i})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   assign pop_data_o = mem_q[rd_ptr_q];
   assign count_o    = cnt_q;
   assign empty_o    = (cnt_q == '0);

endmodule

// File: rtl/sram_port0_req_ctrl.sv
// Port-0 request controller: zero-fills the macro after reset (optional),
// then turns accepted valid/ready requests into macro pin activity, captures
// dout0 one cycle after each read and returns it through a credit-limited FIFO.
module sram_port0_req_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
   parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
   parameter int NUM_WMASKS = SRAM_NUM_WMASKS,
   parameter int RSP_DEPTH  = 2,
   parameter int INIT_EN    = 1
) (
   input  logic                  clk0,
   input  logic                  rst0,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [NUM_WMASKS-1:0] req_wmask,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  init_done,
   output logic                  sram_csb0,
   output logic                  sram_web0,
   output logic [NUM_WMASKS-1:0] sram_wmask0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   input  logic [DATA_WIDTH-1:0] sram_dout0
);

   localparam int CNT_W = $clog2(RSP_DEPTH + 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
   logic                  done_q, done_d;
   logic                  hold_q;          // quiet cycle right after reset
   logic                  rd_inflight_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] din_q;
   logic [NUM_WMASKS-1:0] wmask_q;

   logic                  fire;
   logic                  pop;
   logic                  init_wr;
   logic                  credit_ok;
   logic [CNT_W-1:0]      fifo_cnt;
   logic                  fifo_empty;
   logic [CNT_W:0]        used;
   logic [CNT_W:0]        limit;

   // Outstanding reads (stored + in flight) must stay below the FIFO depth,
   // counting a pop happening this same cycle as a freed slot.
   assign used      = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, rd_inflight_q};
   assign limit     = (CNT_W + 1)'(RSP_DEPTH) + {{CNT_W{1'b0}}, pop};
   assign credit_ok = (used < limit);

   assign req_ready = ~rst0 & ~hold_q & (state_q == ST_RUN) & credit_ok;
   assign fire      = req_valid & req_ready;
   assign init_wr   = ~rst0 & ~hold_q & (state_q == ST_INIT);
   assign rsp_valid = ~rst0 & ~fifo_empty;
   assign pop       = rsp_valid & rsp_ready;
   assign init_done = ~rst0 & done_q;

   // Next-state logic: INIT walks every address once, then RUN forever.
   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      case (state_q)
         ST_INIT: begin
            if (init_wr) begin
               init_cnt_d = init_cnt_q + 1'b1;
               if (init_cnt_q == LAST_ADDR) begin
                  state_d = ST_RUN;
               end
            end
         end
         default: state_d = ST_RUN;
      endcase
      done_d = done_q | (state_d == ST_RUN);
   end

   // Macro pin mux: init writes, live request pins when firing, else hold last values.
   always_comb begin
      sram_csb0   = 1'b1;
      sram_web0   = 1'b1;
      sram_wmask0 = wmask_q;
      sram_addr0  = addr_q;
      sram_din0   = din_q;
      if (init_wr) begin
         sram_csb0   = 1'b0;
         sram_web0   = 1'b0;
         sram_wmask0 = '1;
         sram_addr0  = init_cnt_q;
         sram_din0   = '0;
      end else if (!rst0 && !hold_q && state_q == ST_RUN) begin
         sram_csb0 = ~fire;
         sram_web0 = ~req_we;
         if (fire) begin
            sram_wmask0 = req_we ? req_wmask : '0;
            sram_addr0  = req_addr;
            sram_din0   = req_wdata;
         end
      end
   end

   // State registers, read-in-flight flag and last-driven pin values.
   always_ff @(posedge clk0) begin
      if (rst0) begin
         state_q       <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
         init_cnt_q    <= '0;
         done_q        <= 1'b0;
         hold_q        <= 1'b1;
         rd_inflight_q <= 1'b0;
         addr_q        <= '0;
         din_q         <= '0;
         wmask_q       <= '0;
      end else begin
         state_q       <= state_d;
         init_cnt_q    <= init_cnt_d;
         done_q        <= done_d;
         hold_q        <= 1'b0;
         rd_inflight_q <= fire & ~req_we;
         addr_q        <= sram_addr0;
         din_q         <= sram_din0;
         wmask_q       <= sram_wmask0;
      end
   end

   // Read data appears on dout0 the cycle after the read is issued.
   sram_rsp_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk0        (clk0),
      .rst0        (rst0),
      .push_i      (rd_inflight_q),
      .push_data_i (sram_dout0),
      .pop_i       (pop),
      .pop_data_o  (rsp_rdata),
      .count_o     (fifo_cnt),
      .empty_o     (fifo_empty)
   );

endmodule

// File: tb/tb_sram_port0_req_ctrl.sv
// Directed bench for the port-0 request controller with a behavioural model
// of the single-port macro (pins latched on posedge, array access on negedge).
module tb_sram_port0_req_ctrl;

   logic        clk0 = 1'b0;
   logic        rst0;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [3:0]  req_wmask;
   logic [9:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        init_done;
   logic        sram_csb0;
   logic        sram_web0;
   logic [3:0]  sram_wmask0;
   logic [9:0]  sram_addr0;
   logic [31:0] sram_din0;
   logic [31:0] sram_dout0;

   always #5 clk0 = ~clk0;

   sram_port0_req_ctrl dut (
      .clk0        (clk0),
      .rst0        (rst0),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_wmask   (req_wmask),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .init_done   (init_done),
      .sram_csb0   (sram_csb0),
      .sram_web0   (sram_web0),
      .sram_wmask0 (sram_wmask0),
      .sram_addr0  (sram_addr0),
      .sram_din0   (sram_din0),
      .sram_dout0  (sram_dout0)
   );

   // Macro model
   logic [31:0] mem [1024];
   logic        m_csb = 1'b1;
   logic        m_web = 1'b1;
   logic [3:0]  m_wmask;
   logic [9:0]  m_addr;
   logic [31:0] m_din;

   always @(posedge clk0) begin
      m_csb   <= sram_csb0;
      m_web   <= sram_web0;
      m_wmask <= sram_wmask0;
      m_addr  <= sram_addr0;
      m_din   <= sram_din0;
   end

   always @(negedge clk0) begin
      if (m_csb == 1'b0) begin
         if (m_web == 1'b0) begin
            for (int b = 0; b < 4; b++)
               if (m_wmask[b]) mem[m_addr][b*8 +: 8] <= m_din[b*8 +: 8];
         end else begin
            sram_dout0 <= mem[m_addr];
         end
      end
   end

   // Response collector and pin activity counter
   logic [31:0] got_q [$];
   int          got_cyc [$];
   int          ncyc   = 0;
   int          csb_lo = 0;

   always @(negedge clk0) begin
      ncyc++;
      if (sram_csb0 === 1'b0) csb_lo++;
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
         got_q.push_back(rsp_rdata);
         got_cyc.push_back(ncyc);
         $display("RSP n=%0d data=%08h cyc=%0d", got_q.size(), rsp_rdata, ncyc);
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic sync();
      @(posedge clk0);
      #1;
   endtask

   // Must be entered just after a posedge; returns just after the accepting posedge.
   task automatic do_req(input logic we, input logic [3:0] mask, input logic [9:0] addr,
                         input logic [31:0] data, input int tmo, output bit ok);
      ok        = 1'b0;
      req_valid = 1'b1;
      req_we    = we;
      req_wmask = mask;
      req_addr  = addr;
      req_wdata = data;
      for (int i = 0; i < tmo; i++) begin
         @(negedge clk0);
         if (req_ready === 1'b1) begin
            @(posedge clk0);
            #1;
            ok = 1'b1;
            break;
         end
      end
      $display("REQ we=%0d mask=%h addr=%0d data=%08h accepted=%0d", we, mask, addr, data, ok);
      req_valid = 1'b0;
      req_we    = 1'b0;
   endtask

   task automatic req_ok(input logic we, input logic [3:0] mask, input logic [9:0] addr,
                         input logic [31:0] data);
      bit ok;
      do_req(we, mask, addr, data, 200, ok);
      check_eq("req_accept", ok, 1);
   endtask

   function automatic logic [31:0] exp_low(input int a);
      if (a == 5) return 32'hDEADBEEF;
      if (a == 7) return 32'h11BB33DD;
      return 32'h0;
   endfunction

   localparam logic [31:0] TBL [4] = '{32'h0BADF00D, 32'h13579BDF, 32'h2468ACE0, 32'hFEDCBA98};

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int  writes, bad, first_done, n0, c0;
      bit  ok;

      rst0 = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_wmask = '0;
      req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;

      // Reset state and zero-fill sequence
      @(posedge clk0);
      @(negedge clk0);
      check_eq("rst_csb", sram_csb0, 1);
      check_eq("rst_ready", req_ready, 0);
      check_eq("rst_rsp_valid", rsp_valid, 0);
      check_eq("rst_init_done", init_done, 0);
      @(posedge clk0);
      #1 rst0 = 1'b0;
      @(negedge clk0);
      check_eq("post_rst_csb", sram_csb0, 1);
      check_eq("post_rst_ready", req_ready, 0);
      check_eq("post_rst_done", init_done, 0);

      writes = 0; bad = 0; first_done = -1;
      for (int c = 1; c <= 1100 && first_done < 0; c++) begin
         @(negedge clk0);
         if (sram_csb0 === 1'b0) begin
            writes++;
            if (sram_addr0 !== 10'(c - 1) || sram_din0 !== 32'h0 ||
                sram_wmask0 !== 4'hF || sram_web0 !== 1'b0) bad++;
         end
         if (req_ready === 1'b1 && init_done !== 1'b1) bad++;
         if (init_done === 1'b1) first_done = c;
      end
      check_eq("init_writes", writes, 1024);
      check_eq("init_bad_pins", bad, 0);
      check_eq("init_done_cycle", first_done, 1025);
      sync();

      // Write then read with one-cycle response latency
      n0 = got_q.size();
      req_ok(1'b1, 4'hF, 10'd5, 32'hDEADBEEF);
      req_ok(1'b0, 4'h0, 10'd5, 32'h0);
      @(negedge clk0);
      check_eq("lat_not_yet", rsp_valid, 0);
      @(negedge clk0);
      check_eq("lat_valid", rsp_valid, 1);
      check_eq("lat_data", rsp_rdata, 32'hDEADBEEF);
      repeat (3) @(negedge clk0);
      check_eq("rd5_count", got_q.size() - n0, 1);
      sync();

      // Byte-masked overwrite
      req_ok(1'b1, 4'hF, 10'd7, 32'h11223344);
      req_ok(1'b1, 4'b0101, 10'd7, 32'hAABBCCDD);
      n0 = got_q.size();
      req_ok(1'b0, 4'h0, 10'd7, 32'h0);
      repeat (3) @(negedge clk0);
      check_eq("mask_count", got_q.size() - n0, 1);
      check_eq("mask_data", got_q[n0], 32'h11BB33DD);
      sync();

      // Backpressure: only RSP_DEPTH reads accepted while the consumer stalls
      for (int i = 0; i < 4; i++) req_ok(1'b1, 4'hF, 10'(20 + i), TBL[i]);
      rsp_ready = 1'b0;
      n0 = got_q.size();
      req_ok(1'b0, 4'h0, 10'd20, 32'h0);
      req_ok(1'b0, 4'h0, 10'd21, 32'h0);
      do_req(1'b0, 4'h0, 10'd22, 32'h0, 8, ok);
      check_eq("credit_block", ok, 0);
      @(negedge clk0);
      check_eq("full_ready", req_ready, 0);
      check_eq("full_rsp_valid", rsp_valid, 1);
      check_eq("full_no_pop", got_q.size() - n0, 0);
      sync();
      rsp_ready = 1'b1;
      req_ok(1'b0, 4'h0, 10'd22, 32'h0);
      req_ok(1'b0, 4'h0, 10'd23, 32'h0);
      repeat (6) @(negedge clk0);
      check_eq("bp_count", got_q.size() - n0, 4);
      for (int i = 0; i < 4; i++) check_eq($sformatf("bp_data%0d", i), got_q[n0 + i], TBL[i]);
      sync();

      // Streaming reads, one per cycle
      n0 = got_q.size();
      c0 = csb_lo;
      for (int i = 0; i < 16; i++) req_ok(1'b0, 4'h0, 10'(i), 32'h0);
      repeat (5) @(negedge clk0);
      check_eq("stream_count", got_q.size() - n0, 16);
      check_eq("stream_csb_low", csb_lo - c0, 16);
      check_eq("stream_span", got_cyc[n0 + 15] - got_cyc[n0], 15);
      for (int i = 0; i < 16; i++) check_eq($sformatf("stream_data%0d", i), got_q[n0 + i], exp_low(i));
      sync();

      // Reset with a read in flight and the credit exhausted
      rsp_ready = 1'b0;
      n0 = got_q.size();
      req_ok(1'b0, 4'h0, 10'd20, 32'h0);
      req_ok(1'b0, 4'h0, 10'd21, 32'h0);
      rst0 = 1'b1;
      @(negedge clk0);
      check_eq("mid_rst_csb", sram_csb0, 1);
      check_eq("mid_rst_ready", req_ready, 0);
      @(posedge clk0);
      #1 rsp_ready = 1'b1;
      @(posedge clk0);
      #1 rst0 = 1'b0;
      @(negedge clk0);
      check_eq("rst2_rsp_valid", rsp_valid, 0);
      check_eq("rst2_csb", sram_csb0, 1);
      @(negedge clk0);
      check_eq("rst2_init_csb", sram_csb0, 0);
      check_eq("rst2_init_addr", sram_addr0, 10'd0);
      first_done = -1;
      for (int c = 0; c < 1200 && first_done < 0; c++) begin
         @(negedge clk0);
         if (init_done === 1'b1) first_done = c;
      end
      check_eq("rst2_init_done_seen", first_done >= 0, 1);
      check_eq("rst2_no_rsp", got_q.size() - n0, 0);
      sync();
      n0 = got_q.size();
      req_ok(1'b0, 4'h0, 10'd5, 32'h0);
      repeat (3) @(negedge clk0);
      check_eq("rst2_zeroed", got_q[n0], 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
